// File: rtl/apb_pwm_mc_pkg.sv
// ---------------------------------------------------------------------------
// apb_pwm_mc_pkg
// Shared definitions for the multi-channel APB PWM timer: register offsets
// (decoded from PADDR[7:0]), CTRL field positions, the STATUS PEV bit, the
// counting-direction type and a helper that recognises the CMP[i] window.
// ---------------------------------------------------------------------------
package apb_pwm_mc_pkg;

    // Register offsets within the peripheral's 256-byte window
    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PERIOD   = 8'h04;
    localparam logic [7:0] OFF_COUNTER  = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h10;
    localparam logic [7:0] OFF_CH_EN    = 8'h14;
    localparam logic [7:0] OFF_CH_POL   = 8'h18;
    localparam logic [7:0] OFF_CMP_BASE = 8'h40;

    // CTRL field positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CENTER_BIT = 1;
    localparam int CTRL_PRESC_LSB  = 8;
    localparam int CTRL_PRESC_MSB  = 23;
    localparam int PRESC_WIDTH     = CTRL_PRESC_MSB - CTRL_PRESC_LSB + 1;

    // STATUS field positions
    localparam int STATUS_PEV_BIT = 0;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // CMP[i] lives at 0x40 + 4*i; the index is off[5:2] (range check done by caller)
    function automatic logic is_cmp_window(input logic [7:0] off);
        return (off[7:6] == OFF_CMP_BASE[7:6]) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pwm_mc_timebase.sv
// ---------------------------------------------------------------------------
// pwm_mc_timebase
// Shared prescaled timebase: prescaler pcnt, counter cnt and center-mode
// direction dir, plus period-event generation.
//   HCLK, HRESETn : clock, async active-low reset
//   en            : run enable; when low pcnt/cnt/dir are held at 0/0/up
//   center        : 0 = edge-aligned (sawtooth), 1 = center-aligned (triangle)
//   presc         : tick every presc+1 cycles
//   period        : active PERIOD value
//   cnt           : current counter value (registered)
//   pev           : period event, high in the cycle whose edge restarts the period
// ---------------------------------------------------------------------------
module pwm_mc_timebase
    import apb_pwm_mc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   en,
    input  logic                   center,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic [CNT_WIDTH-1:0]   period,
    output logic [CNT_WIDTH-1:0]   cnt,
    output logic                   pev
);

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PRESC_WIDTH-1:0] PCNT_ONE = PRESC_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    dir_e                   dir_q, dir_d;
    logic                   tick;

    // NOTE: every output of this block is given a default first so that no
    // path leaves a variable unassigned, which would infer a latch.
    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        pev    = 1'b0;
        tick   = 1'b0;

        if (!en) begin
            pcnt_d = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
        end else begin
            tick   = (pcnt_q == presc);
            pcnt_d = tick ? '0 : pcnt_q + PCNT_ONE;

            if (tick) begin
                if (period == '0) begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                    pev   = 1'b1;
                end else if (!center) begin
                    dir_d = DIR_UP;
                    if (cnt_q == period) begin
                        cnt_d = '0;
                        pev   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == period) begin
                        if (period == CNT_ONE) begin
                            // Top and bottom of the triangle are adjacent: the
                            // turn-around lands on 0, so the period ends here.
                            cnt_d = '0;
                            pev   = 1'b1;
                        end else begin
                            cnt_d = period - CNT_ONE;
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // <= 1 rather than == 1 so a mode switch can never underflow
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d = '0;
                        dir_d = DIR_UP;
                        pev   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pcnt_q <= '0;
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
        end else begin
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/apb_pwm_mc.sv
// ---------------------------------------------------------------------------
// apb_pwm_mc
// Multi-channel APB PWM timer with a shared prescaled timebase, edge- or
// center-aligned counting, shadowed PERIOD/CMP registers and a period IRQ.
//   HCLK, HRESETn   : clock, async active-low reset
//   PADDR..PENABLE  : APB slave inputs (offsets decoded from PADDR[7:0])
//   PRDATA          : read data, combinational during a read access, else 0
//   PREADY          : always 1 (zero wait states)
//   PSLVERR         : high during the access phase of an unmapped offset
//   pwm_o[N_CH-1:0] : registered PWM outputs
//   irq_o           : level interrupt, STATUS.PEV & IRQ_EN[0]
// ---------------------------------------------------------------------------
module apb_pwm_mc
    import apb_pwm_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_CH           = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_CH-1:0]           pwm_o,
    output logic                      irq_o
);

    // ---------------- APB decode ----------------
    logic       access, wr, rd, mapped, cmp_sel;
    logic [7:0] off;
    logic       unused_apb;

    assign access = PSEL & PENABLE;
    assign wr     = access & PWRITE;
    assign rd     = access & ~PWRITE;
    assign off    = PADDR[7:0];

    // Upper address bits and write-data bits beyond each field are don't-care
    assign unused_apb = ^{PADDR, PWDATA};

    always_comb begin
        cmp_sel = is_cmp_window(off) && (32'(off[5:2]) < N_CH);
        case (off)
            OFF_CTRL, OFF_PERIOD, OFF_COUNTER, OFF_STATUS,
            OFF_IRQ_EN, OFF_CH_EN, OFF_CH_POL: mapped = 1'b1;
            default:                           mapped = cmp_sel;
        endcase
    end

    // ---------------- registers ----------------
    logic                   ctrl_en_q, ctrl_en_d;
    logic                   ctrl_center_q, ctrl_center_d;
    logic [PRESC_WIDTH-1:0] ctrl_presc_q, ctrl_presc_d;
    logic [CNT_WIDTH-1:0]   period_sh_q, period_sh_d;
    logic [CNT_WIDTH-1:0]   period_act_q, period_act_d;
    logic                   pev_q, pev_d;
    logic                   irq_en_q, irq_en_d;
    logic [N_CH-1:0]        ch_en_q, ch_en_d;
    logic [N_CH-1:0]        ch_pol_q, ch_pol_d;
    logic [CNT_WIDTH-1:0]   cmp_sh_q  [N_CH];
    logic [CNT_WIDTH-1:0]   cmp_sh_d  [N_CH];
    logic [CNT_WIDTH-1:0]   cmp_act_q [N_CH];
    logic [CNT_WIDTH-1:0]   cmp_act_d [N_CH];
    logic [N_CH-1:0]        pwm_q, pwm_d;

    logic [CNT_WIDTH-1:0]   cnt;
    logic                   pev;
    logic                   load_act;
    logic                   pev_clr;

    pwm_mc_timebase #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timebase (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .en      (ctrl_en_q),
        .center  (ctrl_center_q),
        .presc   (ctrl_presc_q),
        .period  (period_act_q),
        .cnt     (cnt),
        .pev     (pev)
    );

    // Active copies follow the shadows at each period boundary, and
    // continuously while stopped so a restart begins with fresh values.
    assign load_act = ~ctrl_en_q | pev;
    assign pev_clr  = wr && (off == OFF_STATUS) && PWDATA[STATUS_PEV_BIT];

    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        ctrl_center_d = ctrl_center_q;
        ctrl_presc_d  = ctrl_presc_q;
        period_sh_d   = period_sh_q;
        irq_en_d      = irq_en_q;
        ch_en_d       = ch_en_q;
        ch_pol_d      = ch_pol_q;
        cmp_sh_d      = cmp_sh_q;

        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    ctrl_en_d     = PWDATA[CTRL_EN_BIT];
                    ctrl_center_d = PWDATA[CTRL_CENTER_BIT];
                    ctrl_presc_d  = PWDATA[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
                end
                OFF_PERIOD: period_sh_d = PWDATA[CNT_WIDTH-1:0];
                OFF_IRQ_EN: irq_en_d    = PWDATA[0];
                OFF_CH_EN:  ch_en_d     = PWDATA[N_CH-1:0];
                OFF_CH_POL: ch_pol_d    = PWDATA[N_CH-1:0];
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (cmp_sel && (off[5:2] == 4'(i))) begin
                            cmp_sh_d[i] = PWDATA[CNT_WIDTH-1:0];
                        end
                    end
                end
            endcase
        end

        period_act_d = load_act ? period_sh_q : period_act_q;
        cmp_act_d    = load_act ? cmp_sh_q    : cmp_act_q;

        // A period event wins over a same-cycle W1C so no event is lost
        pev_d = pev | (pev_q & ~pev_clr);
    end

    // ---------------- per-channel compare ----------------
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic raw;
        assign raw      = (cnt < cmp_act_q[g]);
        assign pwm_d[g] = (ctrl_en_q & ch_en_q[g]) ? (raw ^ ch_pol_q[g]) : ch_pol_q[g];
    end

    // NOTE: the CMP arrays are reset like any other register: their reset
    // value is software-visible, unlike a RAM whose contents are don't-care.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_en_q     <= 1'b0;
            ctrl_center_q <= 1'b0;
            ctrl_presc_q  <= '0;
            period_sh_q   <= '0;
            period_act_q  <= '0;
            pev_q         <= 1'b0;
            irq_en_q      <= 1'b0;
            ch_en_q       <= '0;
            ch_pol_q      <= '0;
            pwm_q         <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cmp_sh_q[i]  <= '0;
                cmp_act_q[i] <= '0;
            end
        end else begin
            ctrl_en_q     <= ctrl_en_d;
            ctrl_center_q <= ctrl_center_d;
            ctrl_presc_q  <= ctrl_presc_d;
            period_sh_q   <= period_sh_d;
            period_act_q  <= period_act_d;
            pev_q         <= pev_d;
            irq_en_q      <= irq_en_d;
            ch_en_q       <= ch_en_d;
            ch_pol_q      <= ch_pol_d;
            pwm_q         <= pwm_d;
            cmp_sh_q      <= cmp_sh_d;
            cmp_act_q     <= cmp_act_d;
        end
    end

    // ---------------- read mux and outputs ----------------
    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_EN_BIT]                   = ctrl_en_q;
                rdata[CTRL_CENTER_BIT]               = ctrl_center_q;
                rdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = ctrl_presc_q;
            end
            OFF_PERIOD:  rdata = 32'(period_sh_q);
            OFF_COUNTER: rdata = 32'(cnt);
            OFF_STATUS:  rdata[STATUS_PEV_BIT] = pev_q;
            OFF_IRQ_EN:  rdata[0] = irq_en_q;
            OFF_CH_EN:   rdata[N_CH-1:0] = ch_en_q;
            OFF_CH_POL:  rdata[N_CH-1:0] = ch_pol_q;
            default: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (cmp_sel && (off[5:2] == 4'(i))) begin
                        rdata = 32'(cmp_sh_q[i]);
                    end
                end
            end
        endcase
    end

    assign PRDATA  = (rd && mapped) ? rdata : '0;
    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;
    assign pwm_o   = pwm_q;
    assign irq_o   = pev_q & irq_en_q;

endmodule

// File: tb/tb_apb_pwm_mc.sv
// ---------------------------------------------------------------------------
// tb_apb_pwm_mc
// Self-checking bench for apb_pwm_mc (N_CH=4, CNT_WIDTH=16). Expected values
// are queued when stimulus is applied and popped when the DUT output is
// sampled (#1 after the rising edge). Expected PWM levels come from a
// closed-form waveform model indexed by cycles since EN was set.
// ---------------------------------------------------------------------------
module tb_apb_pwm_mc;

    localparam logic [11:0] A_CTRL    = 12'h000;
    localparam logic [11:0] A_PERIOD  = 12'h004;
    localparam logic [11:0] A_COUNTER = 12'h008;
    localparam logic [11:0] A_STATUS  = 12'h00C;
    localparam logic [11:0] A_IRQ_EN  = 12'h010;
    localparam logic [11:0] A_CH_EN   = 12'h014;
    localparam logic [11:0] A_CH_POL  = 12'h018;
    localparam logic [11:0] A_CMP0    = 12'h040;
    localparam logic [11:0] A_CMP1    = 12'h044;
    localparam logic [11:0] A_CMP2    = 12'h048;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [3:0]  pwm_o;
    logic        irq_o;

    apb_pwm_mc #(
        .APB_ADDR_WIDTH (12),
        .N_CH           (4),
        .CNT_WIDTH      (16)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pwm_o   (pwm_o),
        .irq_o   (irq_o)
    );

    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // Waveform model parameters
    int         m_presc, m_per;
    bit         m_center;
    int         m_cmp[4];
    logic [3:0] m_pol, m_chen;

    // Expected pwm_o sampled after edge W+c+1, where W is the edge that set EN.
    function automatic logic [3:0] exp_vec(input int c);
        int n, cnt, pos;
        logic [3:0] v;
        n = c / (m_presc + 1);
        if (m_per == 0)     cnt = 0;
        else if (!m_center) cnt = n % (m_per + 1);
        else begin
            pos = n % (2 * m_per);
            cnt = (pos <= m_per) ? pos : 2 * m_per - pos;
        end
        for (int i = 0; i < 4; i++)
            v[i] = m_chen[i] ? ((cnt < m_cmp[i]) ^ m_pol[i]) : m_pol[i];
        return v;
    endfunction

    // Both bus tasks start #1 after a rising edge and return #1 after one.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        #1 d = PRDATA; e = PSLVERR;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        logic        err;
        logic [11:0] good[11];
        logic [11:0] bad[2];
        good = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
                 12'h018, 12'h040, 12'h044, 12'h048, 12'h04C};
        bad  = '{12'h020, 12'h050};
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        exp_q.push_back({28'b0, 4'b0000});                 // pwm_o
        exp_q.push_back({29'b0, 1'b0, 1'b1, 1'b0});        // irq, PREADY, PSLVERR
        e = exp_q.pop_front(); checks++;
        if (pwm_o !== e[3:0]) begin
            errors++; $display("FAIL reset_pwm got %b exp %b", pwm_o, e[3:0]);
        end
        e = exp_q.pop_front(); checks++;
        if ({irq_o, PREADY, PSLVERR} !== e[2:0] || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags got irq/rdy/err=%b prdata=%h exp %b/0",
                     {irq_o, PREADY, PSLVERR}, PRDATA, e[2:0]);
        end
        foreach (good[i]) begin
            exp_q.push_back(32'h0);
            apb_read(good[i], d, err);
            e = exp_q.pop_front(); checks++;
            if (d !== e || err !== 1'b0) begin
                errors++; $display("FAIL reset_read off=%h got %h/%b exp %h/0", good[i], d, err, e);
            end
        end
        foreach (bad[i]) begin
            exp_q.push_back(32'h0);
            apb_read(bad[i], d, err);
            e = exp_q.pop_front(); checks++;
            if (d !== e || err !== 1'b1) begin
                errors++; $display("FAIL unmapped_read off=%h got %h/%b exp %h/1", bad[i], d, err, e);
            end
        end
        // Field truncation on write
        apb_write(A_PERIOD, 32'hABCD_1234);
        apb_write(A_CTRL,   32'hFFFF_FFFE);
        apb_write(A_CH_EN,  32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_1234);
        apb_read(A_PERIOD, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL trunc_period got %h exp %h", d, e); end
        exp_q.push_back(32'h00FF_FF02);
        apb_read(A_CTRL, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL trunc_ctrl got %h exp %h", d, e); end
        exp_q.push_back(32'h0000_000F);
        apb_read(A_CH_EN, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL trunc_ch_en got %h exp %h", d, e); end
        apb_write(A_CTRL, 32'h0);
        apb_write(A_PERIOD, 32'h0);
        apb_write(A_CH_EN, 32'h0);
    endtask

    task automatic test_edge();
        logic [31:0] e;
        apb_write(A_CTRL, 32'h0);
        apb_write(A_PERIOD, 32'd9);
        apb_write(A_CMP0, 32'd3);
        apb_write(A_CH_EN, 32'h1);
        apb_write(A_CH_POL, 32'h0);
        m_presc = 0; m_per = 9; m_center = 0; m_cmp = '{3, 0, 0, 0};
        m_chen = 4'b0001; m_pol = 4'b0000;
        for (int k = 1; k <= 30; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        apb_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 30; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL edge_pwm k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
        end
    endtask

    task automatic test_center();
        logic [31:0] e;
        apb_write(A_CTRL, 32'h0);
        apb_write(A_PERIOD, 32'd4);
        apb_write(A_CMP1, 32'd2);
        apb_write(A_CH_EN, 32'h2);
        apb_write(A_CH_POL, 32'h0);
        m_presc = 0; m_per = 4; m_center = 1; m_cmp = '{3, 2, 0, 0};
        m_chen = 4'b0010; m_pol = 4'b0000;
        for (int k = 1; k <= 16; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        apb_write(A_CTRL, 32'h3);
        for (int k = 1; k <= 16; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL center_pwm k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
        end
        // Polarity flip while running: visible one cycle after its write edge
        apb_write(A_CH_POL, 32'h2);
        m_pol = 4'b0010;
        for (int k = 19; k <= 34; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        for (int k = 19; k <= 34; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL center_pol k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
        end
        apb_write(A_CTRL, 32'h0);
        apb_write(A_CH_POL, 32'h0);
    endtask

    task automatic test_presc_irq();
        logic [31:0] e, d;
        logic        err;
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STATUS, 32'h1);
        apb_write(A_PERIOD, 32'd1);
        apb_write(A_CMP0, 32'd1);
        apb_write(A_CH_EN, 32'h1);
        apb_write(A_CH_POL, 32'h0);
        apb_write(A_IRQ_EN, 32'h1);
        apb_write(A_CTRL, 32'h300);
        exp_q.push_back(32'h300);
        apb_read(A_CTRL, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL presc_ctrl_read got %h exp %h", d, e); end
        m_presc = 3; m_per = 1; m_center = 0; m_cmp = '{1, 0, 0, 0};
        m_chen = 4'b0001; m_pol = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back({28'b0, exp_vec(k - 1)});
            exp_q.push_back({31'b0, (k >= 8)});
        end
        apb_write(A_CTRL, 32'h301);
        for (int k = 1; k <= 16; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL presc_pwm k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
            e = exp_q.pop_front(); checks++;
            if (irq_o !== e[0]) begin
                errors++; $display("FAIL presc_irq k=%0d got %b exp %b", k, irq_o, e[0]);
            end
        end
        // Clear between events (commit at W+18)
        exp_q.push_back(32'h0);
        apb_write(A_STATUS, 32'h1);
        e = exp_q.pop_front(); checks++;
        if (irq_o !== e[0]) begin errors++; $display("FAIL w1c_clear got %b exp %b", irq_o, e[0]); end
        // Clear on the same edge as the event at W+24
        repeat (4) @(posedge HCLK);
        #1;
        exp_q.push_back(32'h1);
        apb_write(A_STATUS, 32'h1);
        e = exp_q.pop_front(); checks++;
        if (irq_o !== e[0]) begin errors++; $display("FAIL w1c_vs_set_irq got %b exp %b", irq_o, e[0]); end
        exp_q.push_back(32'h1);
        apb_read(A_STATUS, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL w1c_vs_set_status got %h exp %h", d, e); end
        exp_q.push_back(32'h0);
        apb_write(A_IRQ_EN, 32'h0);
        e = exp_q.pop_front(); checks++;
        if (irq_o !== e[0]) begin errors++; $display("FAIL irq_mask got %b exp %b", irq_o, e[0]); end
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STATUS, 32'h1);
    endtask

    task automatic test_shadow();
        logic [31:0] e;
        int          vals[2];
        vals = '{0, 12};
        apb_write(A_CTRL, 32'h0);
        apb_write(A_PERIOD, 32'd9);
        apb_write(A_CMP0, 32'd3);
        apb_write(A_CH_EN, 32'h1);
        apb_write(A_CH_POL, 32'h0);
        m_presc = 0; m_per = 9; m_center = 0; m_cmp = '{3, 0, 0, 0};
        m_chen = 4'b0001; m_pol = 4'b0000;
        for (int k = 1; k <= 10; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        m_cmp[0] = 7;
        for (int k = 11; k <= 20; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        apb_write(A_CTRL, 32'h1);
        fork
            apb_write(A_CMP0, 32'd7);
            begin
                for (int k = 1; k <= 20; k++) begin
                    @(posedge HCLK); #1;
                    e = exp_q.pop_front(); checks++;
                    if (pwm_o !== e[3:0]) begin
                        errors++; $display("FAIL shadow_cmp k=%0d got %b exp %b", k, pwm_o, e[3:0]);
                    end
                end
            end
        join
        foreach (vals[v]) begin
            apb_write(A_CTRL, 32'h0);
            apb_write(A_CMP0, 32'(vals[v]));
            m_cmp[0] = vals[v];
            for (int k = 1; k <= 20; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
            apb_write(A_CTRL, 32'h1);
            for (int k = 1; k <= 20; k++) begin
                @(posedge HCLK); #1;
                e = exp_q.pop_front(); checks++;
                if (pwm_o !== e[3:0]) begin
                    errors++;
                    $display("FAIL cmp_limit cmp=%0d k=%0d got %b exp %b", vals[v], k, pwm_o, e[3:0]);
                end
            end
        end
        apb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_en_restart();
        logic [31:0] e, d;
        logic        err;
        apb_write(A_CTRL, 32'h100);
        apb_write(A_PERIOD, 32'd9);
        apb_write(A_CMP0, 32'd3);
        apb_write(A_CMP2, 32'd5);
        apb_write(A_CH_EN, 32'h5);
        apb_write(A_CH_POL, 32'h6);
        m_presc = 1; m_per = 9; m_center = 0; m_cmp = '{3, 0, 5, 0};
        m_chen = 4'b0101; m_pol = 4'b0110;
        for (int k = 1; k <= 5; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        apb_write(A_CTRL, 32'h101);
        for (int k = 1; k <= 5; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL restart_pre k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
        end
        apb_write(A_CTRL, 32'h100);
        exp_q.push_back(32'h0);
        apb_read(A_COUNTER, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e || err !== 1'b0) begin
            errors++; $display("FAIL stop_counter got %h/%b exp %h/0", d, err, e);
        end
        exp_q.push_back({28'b0, 4'b0110});
        e = exp_q.pop_front(); checks++;
        if (pwm_o !== e[3:0]) begin errors++; $display("FAIL stop_pol got %b exp %b", pwm_o, e[3:0]); end
        for (int k = 1; k <= 20; k++) exp_q.push_back({28'b0, exp_vec(k - 1)});
        apb_write(A_CTRL, 32'h101);
        for (int k = 1; k <= 20; k++) begin
            @(posedge HCLK); #1;
            e = exp_q.pop_front(); checks++;
            if (pwm_o !== e[3:0]) begin
                errors++; $display("FAIL restart_post k=%0d got %b exp %b", k, pwm_o, e[3:0]);
            end
        end
        apb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_async_reset();
        logic [31:0] e, d;
        logic        err;
        apb_write(A_PERIOD, 32'd0);
        apb_write(A_CH_EN, 32'h0);
        apb_write(A_CH_POL, 32'h1);
        apb_write(A_STATUS, 32'h1);
        apb_write(A_IRQ_EN, 32'h1);
        apb_write(A_CTRL, 32'h1);
        repeat (3) @(posedge HCLK);
        #1;
        exp_q.push_back({27'b0, 1'b1, 4'b0001});
        e = exp_q.pop_front(); checks++;
        if ({irq_o, pwm_o} !== e[4:0]) begin
            errors++; $display("FAIL pre_reset got %b exp %b", {irq_o, pwm_o}, e[4:0]);
        end
        @(posedge HCLK);
        #3 HRESETn = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({irq_o, pwm_o} !== e[4:0]) begin
            errors++; $display("FAIL async_reset got %b exp %b", {irq_o, pwm_o}, e[4:0]);
        end
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        apb_read(A_CTRL, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL post_reset_ctrl got %h exp %h", d, e); end
        apb_read(A_CH_POL, d, err);
        e = exp_q.pop_front(); checks++;
        if (d !== e) begin errors++; $display("FAIL post_reset_pol got %h exp %h", d, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_presc_irq();
        test_shadow();
        test_en_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
